// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, FSM state
// encodings, ALU one-hot bit positions and the instruction class type.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W  = 5;
  localparam int unsigned REG_W = 4;
  localparam int unsigned ALU_W = 13;
  localparam int unsigned ST_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ST_W-1:0] S_RST   = 4'd0;
  localparam logic [ST_W-1:0] S_T0    = 4'd1;
  localparam logic [ST_W-1:0] S_T1    = 4'd2;
  localparam logic [ST_W-1:0] S_T2    = 4'd3;
  localparam logic [ST_W-1:0] S_T3    = 4'd4;
  localparam logic [ST_W-1:0] S_T4    = 4'd5;
  localparam logic [ST_W-1:0] S_T5    = 4'd6;
  localparam logic [ST_W-1:0] S_T6    = 4'd7;
  localparam logic [ST_W-1:0] S_STALL = 4'd8;
  localparam logic [ST_W-1:0] S_HALT  = 4'd9;

  // alu_op bit positions, AND in the MSB
  localparam int unsigned ALU_AND  = 12;
  localparam int unsigned ALU_OR   = 11;
  localparam int unsigned ALU_ADD  = 10;
  localparam int unsigned ALU_SUB  = 9;
  localparam int unsigned ALU_MUL  = 8;
  localparam int unsigned ALU_DIV  = 7;
  localparam int unsigned ALU_SHR  = 6;
  localparam int unsigned ALU_SHRA = 5;
  localparam int unsigned ALU_SHL  = 4;
  localparam int unsigned ALU_ROR  = 3;
  localparam int unsigned ALU_ROL  = 2;
  localparam int unsigned ALU_NEG  = 1;
  localparam int unsigned ALU_NOT  = 0;

  typedef enum logic [2:0] {
    CL_NOP    = 3'd0,
    CL_ALU    = 3'd1,
    CL_MULDIV = 3'd2,
    CL_UNARY  = 3'd3,
    CL_HALT   = 3'd4
  } op_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: instruction class, one-hot ALU operation and legality.
// Undefined opcodes decode as NOP with legal=0.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output op_class_e        cls,
  output logic [ALU_W-1:0] alu_op,
  output logic             legal
);

  always_comb begin
    cls    = CL_NOP;
    alu_op = '0;
    legal  = 1'b1;
    case (op)
      OP_ADD:  begin cls = CL_ALU;    alu_op[ALU_ADD]  = 1'b1; end
      OP_SUB:  begin cls = CL_ALU;    alu_op[ALU_SUB]  = 1'b1; end
      OP_SHR:  begin cls = CL_ALU;    alu_op[ALU_SHR]  = 1'b1; end
      OP_SHRA: begin cls = CL_ALU;    alu_op[ALU_SHRA] = 1'b1; end
      OP_SHL:  begin cls = CL_ALU;    alu_op[ALU_SHL]  = 1'b1; end
      OP_ROR:  begin cls = CL_ALU;    alu_op[ALU_ROR]  = 1'b1; end
      OP_ROL:  begin cls = CL_ALU;    alu_op[ALU_ROL]  = 1'b1; end
      OP_AND:  begin cls = CL_ALU;    alu_op[ALU_AND]  = 1'b1; end
      OP_OR:   begin cls = CL_ALU;    alu_op[ALU_OR]   = 1'b1; end
      OP_MUL:  begin cls = CL_MULDIV; alu_op[ALU_MUL]  = 1'b1; end
      OP_DIV:  begin cls = CL_MULDIV; alu_op[ALU_DIV]  = 1'b1; end
      OP_NEG:  begin cls = CL_UNARY;  alu_op[ALU_NEG]  = 1'b1; end
      OP_NOT:  begin cls = CL_UNARY;  alu_op[ALU_NOT]  = 1'b1; end
      OP_NOP:  cls = CL_NOP;
      OP_HALT: cls = CL_HALT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch over the datapath bus, decode IR and
// step T-states, driving one-hot register, bus-select and ALU strobes.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = 16,
  parameter int unsigned OPW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       IR,
  input  logic              mem_ready,
  input  logic              stop,
  output logic [NREGS-1:0]  Rin,
  output logic [NREGS-1:0]  Rout,
  output logic              HIin,
  output logic              LOin,
  output logic              HIout,
  output logic              LOout,
  output logic              Zhighout,
  output logic              Zlowout,
  output logic              PCout,
  output logic              PCin,
  output logic              IncPC,
  output logic              MARin,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              Read,
  output logic [ALU_W-1:0]  alu_op,
  output logic              run,
  output logic              illegal
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [OPW-1:0]   op;
  logic [REG_W-1:0] ra, rb, rc;
  logic [NREGS-1:0] ra_oh, rb_oh, rc_oh;
  op_class_e        cls;
  logic [ALU_W-1:0] dec_alu;
  logic             legal;
  logic [ST_W-1:0]  boundary;
  logic             unused_ir;

  assign op        = IR[31 -: OPW];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign ra_oh = NREGS'(1) << ra;
  assign rb_oh = NREGS'(1) << rb;
  assign rc_oh = NREGS'(1) << rc;

  ctrl_decode u_decode (
    .op     (OP_W'(op)),
    .cls    (cls),
    .alu_op (dec_alu),
    .legal  (legal)
  );

  // Where the last T-state of an instruction goes
  assign boundary = stop ? S_STALL : S_T0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = stop ? S_STALL : S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (mem_ready) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        case (cls)
          CL_ALU, CL_MULDIV, CL_UNARY: state_d = S_T4;
          CL_HALT:                     state_d = S_HALT;
          default:                     state_d = boundary;
        endcase
      end
      S_T4:    state_d = (cls == CL_ALU || cls == CL_MULDIV) ? S_T5 : boundary;
      S_T5:    state_d = (cls == CL_MULDIV) ? S_T6 : boundary;
      S_T6:    state_d = boundary;
      S_STALL: if (!stop) state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Moore strobe decode from state plus IR fields
  always_comb begin
    Rin      = '0;
    Rout     = '0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Read     = 1'b0;
    alu_op   = '0;
    run      = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
      end
      S_T1: begin
        run = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        run     = 1'b1;
        illegal = ~legal;
        case (cls)
          CL_ALU:    begin Rout = rb_oh; Yin = 1'b1; end
          CL_MULDIV: begin Rout = ra_oh; Yin = 1'b1; end
          CL_UNARY:  begin Rout = rb_oh; alu_op = dec_alu; Zin = 1'b1; end
          default:   ;
        endcase
      end
      S_T4: begin
        run = 1'b1;
        case (cls)
          CL_ALU:    begin Rout = rc_oh; alu_op = dec_alu; Zin = 1'b1; end
          CL_MULDIV: begin Rout = rb_oh; alu_op = dec_alu; Zin = 1'b1; end
          CL_UNARY:  begin Zlowout = 1'b1; Rin = ra_oh; end
          default:   ;
        endcase
      end
      S_T5: begin
        run = 1'b1;
        case (cls)
          CL_ALU:    begin Zlowout = 1'b1; Rin = ra_oh; end
          CL_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
          default:   ;
        endcase
      end
      S_T6: begin
        run = 1'b1; Zhighout = 1'b1; HIin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven check of the control sequencer's per-state strobes,
// plus hand-written sequences for reset, stop and halt corner cases.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic        mem_ready;
  logic        stop;
  logic [15:0] Rin, Rout;
  logic        HIin, LOin, HIout, LOout, Zhighout, Zlowout;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Read;
  logic [12:0] alu_op;
  logic        run, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .clk(clk), .reset(reset), .IR(IR), .mem_ready(mem_ready), .stop(stop),
    .Rin(Rin), .Rout(Rout), .HIin(HIin), .LOin(LOin), .HIout(HIout),
    .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout),
    .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Read(Read), .alu_op(alu_op),
    .run(run), .illegal(illegal)
  );

  // Single-bit strobes packed into one word for compact expectations
  localparam logic [17:0] C_RUN  = 18'h00001;
  localparam logic [17:0] C_ILL  = 18'h00002;
  localparam logic [17:0] C_READ = 18'h00004;
  localparam logic [17:0] C_ZIN  = 18'h00008;
  localparam logic [17:0] C_YIN  = 18'h00010;
  localparam logic [17:0] C_IRIN = 18'h00020;
  localparam logic [17:0] C_MDRO = 18'h00040;
  localparam logic [17:0] C_MDRI = 18'h00080;
  localparam logic [17:0] C_MARI = 18'h00100;
  localparam logic [17:0] C_INCP = 18'h00200;
  localparam logic [17:0] C_PCIN = 18'h00400;
  localparam logic [17:0] C_PCO  = 18'h00800;
  localparam logic [17:0] C_ZLO  = 18'h01000;
  localparam logic [17:0] C_ZHI  = 18'h02000;
  localparam logic [17:0] C_LOIN = 18'h10000;
  localparam logic [17:0] C_HIIN = 18'h20000;

  localparam logic [17:0] F0 = C_RUN | C_PCO | C_MARI | C_INCP | C_PCIN;
  localparam logic [17:0] F1 = C_RUN | C_READ | C_MDRI;
  localparam logic [17:0] F2 = C_RUN | C_MDRO | C_IRIN;

  localparam logic [12:0] A_ADD = 13'h0400;
  localparam logic [12:0] A_MUL = 13'h0100;
  localparam logic [12:0] A_NOT = 13'h0001;

  localparam logic [31:0] I_ADD  = 32'h1A1B8000;
  localparam logic [31:0] I_NOT  = 32'h92380000;
  localparam logic [31:0] I_MUL  = 32'h79B80000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_BAD  = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  typedef struct {
    logic        stop;
    logic        mr;
    logic [31:0] ir;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [12:0] alu;
    logic [17:0] ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic m, input logic [31:0] ir,
                     input logic [15:0] rin, input logic [15:0] rout,
                     input logic [12:0] alu, input logic [17:0] ctl);
    vec_t v;
    v.stop = s; v.mr = m; v.ir = ir; v.rin = rin; v.rout = rout;
    v.alu = alu; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  function automatic logic [17:0] ctl_act();
    return {HIin, LOin, HIout, LOout, Zhighout, Zlowout, PCout, PCin, IncPC,
            MARin, MDRin, MDRout, IRin, Yin, Zin, Read, illegal, run};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic [15:0] rin,
                         input logic [15:0] rout, input logic [12:0] alu,
                         input logic [17:0] ctl);
    chk({nm, ".rin"},  idx, 32'(Rin),       32'(rin));
    chk({nm, ".rout"}, idx, 32'(Rout),      32'(rout));
    chk({nm, ".alu"},  idx, 32'(alu_op),    32'(alu));
    chk({nm, ".ctl"},  idx, 32'(ctl_act()), 32'(ctl));
  endtask

  task automatic step(input logic s, input logic m);
    stop = s; mem_ready = m;
    @(negedge clk);
  endtask

  initial begin
    // S_RST, then ADD R4,R3,R7
    add(0, 1, I_ADD, 16'h0, 16'h0, 13'h0, 18'h0);
    add(0, 1, I_ADD, 16'h0, 16'h0, 13'h0, F0);
    add(0, 1, I_ADD, 16'h0, 16'h0, 13'h0, F1);
    add(0, 1, I_ADD, 16'h0, 16'h0, 13'h0, F2);
    add(0, 1, I_ADD, 16'h0, 16'h0008, 13'h0, C_RUN | C_YIN);
    add(0, 1, I_ADD, 16'h0, 16'h0080, A_ADD, C_RUN | C_ZIN);
    add(0, 1, I_ADD, 16'h0010, 16'h0, 13'h0, C_RUN | C_ZLO);
    // NOT R4,R7: five cycles
    add(0, 1, I_NOT, 16'h0, 16'h0, 13'h0, F0);
    add(0, 1, I_NOT, 16'h0, 16'h0, 13'h0, F1);
    add(0, 1, I_NOT, 16'h0, 16'h0, 13'h0, F2);
    add(0, 1, I_NOT, 16'h0, 16'h0080, A_NOT, C_RUN | C_ZIN);
    add(0, 1, I_NOT, 16'h0010, 16'h0, 13'h0, C_RUN | C_ZLO);
    // MUL R3,R7: seven cycles
    add(0, 1, I_MUL, 16'h0, 16'h0, 13'h0, F0);
    add(0, 1, I_MUL, 16'h0, 16'h0, 13'h0, F1);
    add(0, 1, I_MUL, 16'h0, 16'h0, 13'h0, F2);
    add(0, 1, I_MUL, 16'h0, 16'h0008, 13'h0, C_RUN | C_YIN);
    add(0, 1, I_MUL, 16'h0, 16'h0080, A_MUL, C_RUN | C_ZIN);
    add(0, 1, I_MUL, 16'h0, 16'h0, 13'h0, C_RUN | C_ZLO | C_LOIN);
    add(0, 1, I_MUL, 16'h0, 16'h0, 13'h0, C_RUN | C_ZHI | C_HIIN);
    // NOP with three wait states in T1
    add(0, 1, I_NOP, 16'h0, 16'h0, 13'h0, F0);
    add(0, 0, I_NOP, 16'h0, 16'h0, 13'h0, F1);
    add(0, 0, I_NOP, 16'h0, 16'h0, 13'h0, F1);
    add(0, 0, I_NOP, 16'h0, 16'h0, 13'h0, F1);
    add(0, 1, I_NOP, 16'h0, 16'h0, 13'h0, F1);
    add(0, 1, I_NOP, 16'h0, 16'h0, 13'h0, F2);
    add(0, 1, I_NOP, 16'h0, 16'h0, 13'h0, C_RUN);
    // Undefined opcode
    add(0, 1, I_BAD, 16'h0, 16'h0, 13'h0, F0);
    add(0, 1, I_BAD, 16'h0, 16'h0, 13'h0, F1);
    add(0, 1, I_BAD, 16'h0, 16'h0, 13'h0, F2);
    add(0, 1, I_BAD, 16'h0, 16'h0, 13'h0, C_RUN | C_ILL);
    // ADD with stop raised before the boundary
    add(0, 1, I_ADD, 16'h0, 16'h0, 13'h0, F0);
    add(0, 1, I_ADD, 16'h0, 16'h0, 13'h0, F1);
    add(0, 1, I_ADD, 16'h0, 16'h0, 13'h0, F2);
    add(1, 1, I_ADD, 16'h0, 16'h0008, 13'h0, C_RUN | C_YIN);
    add(1, 1, I_ADD, 16'h0, 16'h0080, A_ADD, C_RUN | C_ZIN);
    add(1, 1, I_ADD, 16'h0010, 16'h0, 13'h0, C_RUN | C_ZLO);
    add(1, 1, I_ADD, 16'h0, 16'h0, 13'h0, 18'h0);
    add(0, 1, I_ADD, 16'h0, 16'h0, 13'h0, 18'h0);
    // HALT: held for 10 cycles even with stop toggling
    add(0, 1, I_HALT, 16'h0, 16'h0, 13'h0, F0);
    add(0, 1, I_HALT, 16'h0, 16'h0, 13'h0, F1);
    add(0, 1, I_HALT, 16'h0, 16'h0, 13'h0, F2);
    add(0, 1, I_HALT, 16'h0, 16'h0, 13'h0, C_RUN);
    for (int k = 0; k < 10; k++)
      add(logic'(k % 2), 1, I_HALT, 16'h0, 16'h0, 13'h0, 18'h0);

    reset = 1'b1; stop = 1'b0; mem_ready = 1'b1; IR = I_ADD;
    @(negedge clk);
    chk_all("reset_hold", 0, 16'h0, 16'h0, 13'h0, 18'h0);
    @(negedge clk);
    chk_all("reset_hold", 1, 16'h0, 16'h0, 13'h0, 18'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      stop = vecs[i].stop; mem_ready = vecs[i].mr; IR = vecs[i].ir;
      #1;
      chk_all("vec", i, vecs[i].rin, vecs[i].rout, vecs[i].alu, vecs[i].ctl);
      @(negedge clk);
    end

    // Async reset while halted; stop held across release goes to stall
    #2 reset = 1'b1; stop = 1'b1;
    #1 chk_all("halt_reset", 0, 16'h0, 16'h0, 13'h0, 18'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_all("rst_release", 0, 16'h0, 16'h0, 13'h0, 18'h0);
    step(1, 1);
    #1 chk_all("rst_stall", 0, 16'h0, 16'h0, 13'h0, 18'h0);
    step(0, 1);
    #1 chk_all("stall_exit", 0, 16'h0, 16'h0, 13'h0, F0);

    // Async reset in the middle of an ALU instruction aborts at once
    IR = I_ADD;
    step(0, 1);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    #1 chk_all("mid_t4", 0, 16'h0, 16'h0080, A_ADD, C_RUN | C_ZIN);
    #2 reset = 1'b1;
    #1 chk_all("mid_reset", 0, 16'h0, 16'h0, 13'h0, 18'h0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 1);
    #1 chk_all("restart_t0", 0, 16'h0, 16'h0, 13'h0, F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the existing `datapath` control inputs, replacing bench-driven stimulus.
- Fetches over the datapath bus, decodes the instruction register value, and steps a Moore FSM through T-states.
- Asserts the one-hot register-enable, bus-select and ALU-op strobes the datapath expects.
- Covers the register-register ALU subset, MUL/DIV to HI/LO, NEG/NOT, NOP and HALT.

Parameters:
- NREGS, 16, general-purpose register count; width of Rin/Rout.
- OPW, 5, opcode field width (IR[31:27]).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IR  in  32  datapath instruction register contents.
- mem_ready  in  1  memory read-data valid.
- stop  in  1  request to pause at the next instruction boundary.
- Rin  out  16  one-hot register load (bit n = Rn in).
- Rout  out  16  one-hot register bus drive.
- HIin, LOin, HIout, LOout, Zhighout, Zlowout  out  1 each  HI/LO/Z strobes.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Read  out  1 each  datapath strobes.
- alu_op  out  13  one-hot ALU op {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}, bit 12 = AND.
- run  out  1  high while executing.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Fields: op = IR[31:27], Ra = IR[26:23] (destination), Rb = IR[22:19], Rc = IR[18:15].
- States: S_RST, T0..T6, S_STALL, S_HALT (4-bit encoding).
- All outputs are Moore, decoded from the registered state plus IR fields. IR is stable from T3 onward.
- Reset: async; state goes to S_RST and every output is 0, including run.
- S_RST -> T0 on the next edge, or S_STALL if stop=1.
- T0: PCout, MARin, IncPC, PCin.
- T1: Read, MDRin. Hold T1 while mem_ready=0; advance when mem_ready=1.
- T2: MDRout, IRin.
- Binary ALU ops (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], alu_op[op], Zin.
  - T5: Zlowout, Rin[Ra].
  - Then to T0.
- MUL/DIV:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], alu_op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Then to T0.
- NEG/NOT:
  - T3: Rout[Rb], alu_op, Zin.
  - T4: Zlowout, Rin[Ra].
  - Then to T0.
- NOP: T3 with all strobes 0, then to T0.
- HALT: T3 -> S_HALT. All outputs 0, run=0. Held until reset.
- Undefined opcode: behaves as NOP; illegal=1 during T3 only.
- Instruction boundary: the last T-state of each instruction goes to S_STALL if stop=1, else to T0.
- S_STALL: all outputs 0, run=0. -> T0 when stop=0.
- run=1 in T0..T6; 0 in S_RST, S_STALL, S_HALT.
- At most one bit of Rout set; at most one bit of Rin set; at most one bus-source strobe per state.
- R0 has no special case.
- Reset mid-instruction aborts immediately. No strobe may remain asserted after reset assertion.
- Cycle counts with mem_ready=1: ALU = 6; MUL/DIV = 7; NEG/NOT = 5; NOP = 4.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode localparams: ADD=00011, SUB=00100, SHR=00101, SHRA=00110, SHL=00111, ROR=01000, ROL=01001, AND=01010, OR=01011, MUL=01111, DIV=10000, NEG=10001, NOT=10010, NOP=11010, HALT=11011.
  - state encodings.
  - alu_op bit indices.
- One sub-module: ctrl_decode, combinational op -> {class, alu_op one-hot, legal}.
- FSM and strobe decode stay in control_sequencer.

Test Plan:
- Reset, then no stop, mem_ready=1 -> S_RST for one cycle, T0 next with PCout=MARin=IncPC=PCin=1. All outputs 0 while reset is high.
- IR=0x1A1B8000 (ADD R4,R3,R7) -> each state asserts exactly its listed strobes:
  - T3: Rout=0x0008, Yin.
  - T4: Rout=0x0080, alu_op ADD, Zin.
  - T5: Zlowout, Rin=0x0010.
  - Then T0.
- IR=0x92380000 (NOT R4,R7) -> T3: Rout=0x0080, alu_op NOT, Zin; T4: Zlowout, Rin=0x0010; 5-cycle instruction.
- IR=0x79B80000 (MUL R3,R7) -> T5 LOin with Zlowout, T6 HIin with Zhighout, then T0; 7 cycles.
- mem_ready low 3 cycles in T1 -> Read=MDRin=1 held 4 cycles. Assert stop during ADD -> S_STALL after T5, run=0; release -> T0.
- IR=0xF8000000 -> illegal pulses 1 cycle in T3, back to T0. IR=0xD8000000 -> S_HALT, run=0, persists 10 cycles; async reset mid-HALT -> S_RST.
